instruction_loader: RTL and testbench

Host-side writer for the DDS instruction block memories. It accepts a byte stream over a valid/ready handshake and packs each pair of bytes into one 11-bit instruction word. Each word is written to sequential addresses through a single BRAM write port, filling the memory that the playback instruction counters later read. One instance sits in front of each instruction memory, on port A, before playback is released from reset.

---
 rtl/instruction_loader.sv | 169 ++++++++++++++++
 tb/tb_instruction_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Purpose: packs a byte stream (low byte, then high byte) into DATA_WIDTH-bit words and
//          writes them to sequential addresses 0..NUM_WORDS-1 of one BRAM write port.
// Latency: wea is asserted the cycle after the high byte is accepted; 3 cycles/word at best.
// Backpressure: s_ready is low during the write cycle and whenever no load is in progress.
//
// Ports:
//   clk, reset                - rising-edge clock, asynchronous active-high reset
//   start                     - one-cycle pulse, begins a load at address 0 (ignored while busy)
//   s_data/s_valid/s_ready    - byte stream, valid/ready handshake
//   wea/addr/din              - registered BRAM write port
//   busy/done/word_count      - load status (done is sticky until the next accepted start)
//   format_err                - sticky; a high byte carried nonzero unused bits
//   chk_err                   - sticky checksum mismatch; tied low unless LOADER_CHECKSUM_EN
//
// Build option: define LOADER_CHECKSUM_EN to append one XOR checksum byte after the last word.

module instruction_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 17,
    parameter int NUM_WORDS  = 66583
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  format_err,
    output logic                  chk_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WR,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   WORD_SAT  = (ADDR_WIDTH + 1)'(NUM_WORDS);

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            lo_byte;
    logic                  accept;

    assign accept = s_valid && s_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
`else
    assign chk_err = 1'b0;
`endif

    // All outputs are registered; each transition sets the flags for the state it enters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            lo_byte    <= '0;
            s_ready    <= 1'b0;
            wea        <= 1'b0;
            addr       <= '0;
            din        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            format_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_err    <= 1'b0;
            csum       <= '0;
`endif
        end else begin
            wea <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LO;
                        idx        <= '0;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        word_count <= '0;
                        format_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        chk_err    <= 1'b0;
                        csum       <= '0;
`endif
                    end
                end

                S_LO: begin
                    if (accept) begin
                        lo_byte <= s_data;
                        state   <= S_HI;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ s_data;
`endif
                    end
                end

                S_HI: begin
                    if (accept) begin
                        addr    <= idx;
                        din     <= {s_data[DATA_WIDTH-9:0], lo_byte};
                        // Bits above the word width are dropped but flagged.
                        if ((s_data >> (DATA_WIDTH - 8)) != 8'd0) begin
                            format_err <= 1'b1;
                        end
                        wea     <= 1'b1;
                        s_ready <= 1'b0;
                        state   <= S_WR;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ s_data;
`endif
                    end
                end

                S_WR: begin
                    if (word_count != WORD_SAT) begin
                        word_count <= word_count + (ADDR_WIDTH + 1)'(1);
                    end
                    if (idx == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                        state   <= S_CHK;
                        s_ready <= 1'b1;
`else
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        // idx stays at the last address at the end of a load, so it never wraps.
                        idx     <= idx + ADDR_WIDTH'(1);
                        state   <= S_LO;
                        s_ready <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        chk_err <= (s_data != csum);
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
`endif

                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Purpose: randomized self-checking bench for instruction_loader (NUM_WORDS=4).
// Latency: expected writes come from a byte-list model; write spacing checked at 3 cycles.
// Backpressure: random s_valid gaps and start pokes while busy must not change results.

module tb_instruction_loader;

    localparam int DW = 11;
    localparam int AW = 17;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
    logic          format_err;
    logic          chk_err;

    instruction_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wea       (wea),
        .addr      (addr),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .word_count(word_count),
        .format_err(format_err),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]    tx [0:15];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_dat_q  [$];
    int            wr_cyc_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side observer: every cycle with wea high is one write.
    always @(negedge clk) begin
        if (!reset && wea) begin
            wr_addr_q.push_back(addr);
            wr_dat_q.push_back(din);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams tx[0..n-1]; gap_pct is the percentage of idle cycles, poke adds start pulses.
    task automatic send_bytes(input int n, input int gap_pct, input bit poke);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? tx[sent] : 8'($urandom);
            start   = poke && ($urandom_range(3) == 0);
            if (s_valid && s_ready) sent++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
        chk("send_all_bytes", sent, n);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", done, 1);
    endtask

    // One complete load of the current tx[] contents, checked against the byte-list model.
    task automatic run_load(input int gap_pct, input bit poke, input bit bad_csum, input string tag);
        int         nbytes;
        bit         exp_fmt;
        bit         exp_chk;
        int         exp_w [NW];
        logic [7:0] x;

        exp_fmt = 1'b0;
        x       = 8'h00;
        for (int i = 0; i < NW; i++) begin
            exp_w[i] = (int'(tx[2*i+1]) % (1 << (DW - 8))) * 256 + int'(tx[2*i]);
            if (int'(tx[2*i+1]) >= (1 << (DW - 8))) exp_fmt = 1'b1;
            x = x ^ tx[2*i] ^ tx[2*i+1];
        end
`ifdef LOADER_CHECKSUM_EN
        nbytes     = 2 * NW + 1;
        tx[2 * NW] = bad_csum ? (x ^ 8'(1 + $urandom_range(254))) : x;
        exp_chk    = bad_csum;
`else
        nbytes  = 2 * NW;
        exp_chk = 1'b0 & bad_csum;
`endif

        pulse_start();
        chk({tag, "_start_busy"}, busy, 1);
        chk({tag, "_start_done_clr"}, done, 0);
        chk({tag, "_start_cnt_clr"}, word_count, 0);
        wr_addr_q.delete();
        wr_dat_q.delete();
        wr_cyc_q.delete();

        send_bytes(nbytes, gap_pct, poke);
        wait_done();

        chk({tag, "_nwrites"}, wr_addr_q.size(), NW);
        for (int i = 0; i < NW && i < wr_addr_q.size(); i++) begin
            chk({tag, "_addr"}, wr_addr_q[i], i);
            chk({tag, "_din"}, wr_dat_q[i], exp_w[i]);
            if (gap_pct == 0 && !poke && i > 0)
                chk({tag, "_spacing"}, wr_cyc_q[i] - wr_cyc_q[i-1], 3);
        end
        chk({tag, "_word_count"}, word_count, NW);
        chk({tag, "_format_err"}, format_err, exp_fmt);
        chk({tag, "_chk_err"}, chk_err, exp_chk);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_ready_low"}, s_ready, 0);
        chk({tag, "_addr_hold"}, addr, NW - 1);
        chk({tag, "_din_hold"}, din, exp_w[NW-1]);
    endtask

    task automatic load_scenario1();
        logic [7:0] b [0:7];
        b = '{8'h34, 8'h02, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h01, 8'h05};
        for (int i = 0; i < 8; i++) tx[i] = b[i];
    endtask

    initial begin
        int nw_before;
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wea", wea, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_format_err", format_err, 0);
        chk("rst_chk_err", chk_err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_word_count", word_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Continuous stream of the reference bytes.
        load_scenario1();
        run_load(0, 1'b0, 1'b0, "s1");

        // Bytes offered in DONE are not consumed.
        nw_before = wr_addr_q.size();
        repeat (6) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("done_ignore_writes", wr_addr_q.size(), nw_before);
        chk("done_ignore_cnt", word_count, NW);
        chk("done_sticky", done, 1);

        // A single high byte with an unused bit set.
        load_scenario1();
        tx[3] = 8'h0A;
        run_load(0, 1'b0, 1'b0, "fmt");
        chk("fmt_din_hi", wr_dat_q.size() > 1 ? 32'(wr_dat_q[1] >> 8) : 32'hFFFF, 3'b010);

        // Gapped stream with start pokes while busy: same result as the first load.
        load_scenario1();
        run_load(40, 1'b1, 1'b0, "gap");

        // Reset after 5 bytes.
        load_scenario1();
        pulse_start();
        wr_addr_q.delete();
        wr_dat_q.delete();
        wr_cyc_q.delete();
        send_bytes(5, 0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wea", wea, 0);
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_din", din, 0);
        chk("mid_rst_cnt", word_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("mid_rst_writes", wr_addr_q.size(), 2);
        chk("mid_rst_idle", busy, 0);
        run_load(0, 1'b0, 1'b0, "after_rst");

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2 * NW; i++) begin
                tx[i] = ((i % 2) == 1 && $urandom_range(1) == 0) ? 8'($urandom_range(7)) : 8'($urandom);
            end
            run_load(int'($urandom_range(60)), 1'($urandom_range(1)), 1'($urandom_range(1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
